// File: rtl/pulse_burst_gen.sv
// Burst scheduler: queues {count, spacing} requests and emits single-cycle strobes
// with clamped spacing, per-burst done pulses, a post-burst tail gap and a synchronous flush.
module pulse_burst_gen #(
    parameter int CNT_W       = 8,
    parameter int GAP_W       = 8,
    parameter int MIN_SPACING = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_count,
    input  logic [GAP_W-1:0] req_spacing,
    output logic             pulse_narrow,
    output logic             done,
    output logic             busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = CNT_W + GAP_W;
    localparam logic [GAP_W-1:0] MIN_S     = GAP_W'(MIN_SPACING);
    localparam logic [GAP_W-1:0] TAIL_INIT = GAP_W'(MIN_SPACING - 2);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, TAIL} state_t;

    state_t           state;
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [CNT_W-1:0] remaining;
    logic [GAP_W-1:0] spacing;
    logic [GAP_W-1:0] gap_cnt;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] head_count;
    logic [GAP_W-1:0] head_spacing;
    logic [GAP_W-1:0] eff_spacing;

    // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
    // req_valid may be held while waiting, and fields must be stable while it is high.
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign req_ready = !full && !flush && !rst;
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && !empty && !flush;
    assign busy      = (state != IDLE) || !empty;

    assign head_count   = mem[rd_ptr][ENT_W-1:GAP_W];
    assign head_spacing = mem[rd_ptr][GAP_W-1:0];
    assign eff_spacing  = (head_spacing < MIN_S) ? MIN_S : head_spacing;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_count, req_spacing};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Gap and tail counters load (length - 2) so each phase lasts (length - 1) cycles,
    // putting consecutive strobes exactly S apart and the tail at MIN_SPACING + 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            spacing      <= '0;
            gap_cnt      <= '0;
            pulse_narrow <= 1'b0;
            done         <= 1'b0;
        end else if (flush) begin
            state        <= IDLE;
            remaining    <= '0;
            spacing      <= '0;
            gap_cnt      <= '0;
            pulse_narrow <= 1'b0;
            done         <= 1'b0;
        end else begin
            pulse_narrow <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        remaining <= head_count;
                        spacing   <= eff_spacing;
                        if (head_count != '0) begin
                            state        <= PULSE;
                            pulse_narrow <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                PULSE: begin
                    remaining <= remaining - 1'b1;
                    if (remaining > CNT_W'(1)) begin
                        state   <= GAP;
                        gap_cnt <= spacing - GAP_W'(2);
                    end else begin
                        state   <= TAIL;
                        gap_cnt <= TAIL_INIT;
                        done    <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state        <= PULSE;
                        pulse_narrow <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                TAIL: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed bench for pulse_burst_gen: logs strobe/done/acceptance cycles and
// compares them with hand-computed schedules.
module tb_pulse_burst_gen;
    localparam int CNT_W = 8;
    localparam int GAP_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [CNT_W-1:0] req_count = '0;
    logic [GAP_W-1:0] req_spacing = '0;
    logic             pulse_narrow;
    logic             done;
    logic             busy;

    int checks = 0;
    int failures = 0;

    logic [31:0] cyc = '0;
    logic [31:0] strobe_q[$];
    logic [31:0] done_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] busy_fall_q[$];
    logic [31:0] exp_strobe_q[$];
    logic [31:0] exp_done_q[$];
    logic        busy_prev = 1'b0;
    logic        pulse_d = 1'b0;
    logic        wide_prev = 1'b0;
    int          wide_rises = 0;
    logic [31:0] k;

    pulse_burst_gen #(
        .CNT_W(CNT_W), .GAP_W(GAP_W), .MIN_SPACING(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_count(req_count), .req_spacing(req_spacing),
        .pulse_narrow(pulse_narrow), .done(done), .busy(busy)
    );

    // clock and cycle labels: after edge number k, cyc == k
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) acc_q.push_back(cyc + 1);
        pulse_d <= pulse_narrow;
    end

    // model of the widening stage: each strobe stretched to two cycles
    always @(negedge clk) begin
        if (!rst) begin
            if (pulse_narrow) strobe_q.push_back(cyc);
            if (done) done_q.push_back(cyc);
            if (busy_prev && !busy) busy_fall_q.push_back(cyc);
            if ((pulse_narrow || pulse_d) && !wide_prev) wide_rises <= wide_rises + 1;
        end
        busy_prev <= busy;
        wide_prev <= pulse_narrow || pulse_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        strobe_q.delete();
        done_q.delete();
        acc_q.delete();
        busy_fall_q.delete();
        exp_strobe_q.delete();
        exp_done_q.delete();
        wide_rises = 0;
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_n_strobe"}, strobe_q.size(), exp_strobe_q.size());
        for (int i = 0; i < strobe_q.size() && i < exp_strobe_q.size(); i++)
            check({tag, "_strobe"}, strobe_q[i], exp_strobe_q[i]);
        check({tag, "_n_done"}, done_q.size(), exp_done_q.size());
        for (int i = 0; i < done_q.size() && i < exp_done_q.size(); i++)
            check({tag, "_done"}, done_q[i], exp_done_q[i]);
    endtask

    // driver: entered and left at a falling edge; leaves req_valid high for chaining
    task automatic push_req(input int n, input int sp);
        int guard;
        req_valid   = 1'b1;
        req_count   = CNT_W'(n);
        req_spacing = GAP_W'(sp);
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("push_ready", {31'b0, req_ready}, 32'd1);
        if (req_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        // reset state
        #12;
        check("rst_pulse", {31'b0, pulse_narrow}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_ready", {31'b0, req_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, req_ready}, 1);
        check("post_rst_busy", {31'b0, busy}, 0);
        @(negedge clk);

        // single burst N=3, spacing 6
        clear_logs();
        push_req(3, 6);
        req_valid = 1'b0;
        repeat (30) @(negedge clk);
        k = acc_q[0];
        exp_strobe_q = '{k + 1, k + 7, k + 13};
        exp_done_q   = '{k + 14};
        compare_logs("single");
        check("single_n_busy_fall", busy_fall_q.size(), 1);
        if (busy_fall_q.size() > 0) check("single_busy_fall", busy_fall_q[0], k + 17);

        // clamped spacing N=4, spacing 1
        clear_logs();
        push_req(4, 1);
        req_valid = 1'b0;
        repeat (30) @(negedge clk);
        k = acc_q[0];
        exp_strobe_q = '{k + 1, k + 5, k + 9, k + 13};
        exp_done_q   = '{k + 14};
        compare_logs("clamp");
        check("clamp_wide_rises", wide_rises, 4);

        // five back-to-back requests into a depth-4 queue
        clear_logs();
        for (int i = 0; i < 5; i++) push_req(2, 5);
        req_valid = 1'b0;
        #1;
        check("full_ready_low", {31'b0, req_ready}, 0);
        k = acc_q[0];
        check("full_acc_last", acc_q[4], k + 4);
        repeat (6) @(negedge clk);
        check("full_ready_k10", {31'b0, req_ready}, 0);
        @(negedge clk);
        check("full_ready_k11", {31'b0, req_ready}, 1);
        repeat (50) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            exp_strobe_q.push_back(k + 1 + 10 * i);
            exp_strobe_q.push_back(k + 6 + 10 * i);
            exp_done_q.push_back(k + 7 + 10 * i);
        end
        compare_logs("fifo");

        // zero-length request followed by a single strobe
        clear_logs();
        push_req(0, 4);
        push_req(1, 4);
        req_valid = 1'b0;
        repeat (15) @(negedge clk);
        k = acc_q[0];
        exp_strobe_q = '{k + 2};
        exp_done_q   = '{k + 1, k + 3};
        compare_logs("zero");

        // flush during GAP with two entries queued
        clear_logs();
        push_req(5, 6);
        push_req(1, 4);
        push_req(1, 4);
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_ready_low", {31'b0, req_ready}, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", {31'b0, busy}, 0);
        check("flush_ready", {31'b0, req_ready}, 1);
        check("flush_pulse", {31'b0, pulse_narrow}, 0);
        push_req(1, 0);
        req_valid = 1'b0;
        repeat (20) @(negedge clk);
        k = acc_q[0];
        check("flush_n_acc", acc_q.size(), 4);
        exp_strobe_q = '{k + 1, k + 7, acc_q[3] + 1};
        exp_done_q   = '{acc_q[3] + 2};
        compare_logs("flush");

        // asynchronous reset while a strobe is high
        clear_logs();
        push_req(3, 4);
        req_valid = 1'b0;
        @(negedge clk);
        check("arst_pulse_before", {31'b0, pulse_narrow}, 1);
        rst = 1'b1;
        #1;
        check("arst_pulse", {31'b0, pulse_narrow}, 0);
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_ready", {31'b0, req_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_ready_after", {31'b0, req_ready}, 1);
        check("arst_busy_after", {31'b0, busy}, 0);
        clear_logs();
        repeat (20) @(negedge clk);
        compare_logs("arst_idle");
        push_req(2, 4);
        req_valid = 1'b0;
        repeat (20) @(negedge clk);
        k = acc_q[0];
        exp_strobe_q = '{k + 1, k + 5};
        exp_done_q   = '{k + 6};
        compare_logs("arst_new");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
